video_pll_sequencer: RTL and testbench

//  Controls the video PLL and the pixel-clock selector. Sequences PLL reset and lock

---
 rtl/video_pll_seq_pkg.sv | 36 +++
 rtl/video_pll_lock_sync.sv | 31 +++
 rtl/video_pll_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_video_pll_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_pll_seq_pkg
//  Brief    : Shared state encoding, mode codes and helpers for the video PLL
//             sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package video_pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        GATE_ON   = 3'd3,
        RUN       = 3'd4,
        SW_OFF    = 3'd5,
        SW_SEL    = 3'd6,
        FAULT     = 3'd7
    } state_t;

    localparam logic [1:0] MODE_25      = 2'd0;
    localparam logic [1:0] MODE_40      = 2'd1;
    localparam logic [1:0] MODE_33      = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_pll_lock_sync.sv
`default_nettype none
// ============================================================================
//  Module   : video_pll_lock_sync
//  Brief    : Two-flop synchronizer bringing the asynchronous PLL lock flag
//             into the reference clock domain.
//  Revision : 1.0 - initial release
// ============================================================================
module video_pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/video_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : video_pll_sequencer
//  Brief    : Video PLL reset/lock sequencing and glitch-free pixel-clock
//             switching. Optional statistics ports: VIDEO_PLL_SEQ_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module video_pll_sequencer
    import video_pll_seq_pkg::*;
#(
    parameter int         PLL_RST_CYCLES = 16,
    parameter int         LOCK_TIMEOUT   = 50000,
    parameter int         LOCK_STABLE    = 256,
    parameter int         GATE_CYCLES    = 8,
    parameter int         MAX_RETRY      = 3,
    parameter logic [1:0] MODE_DEFAULT   = 2'd0
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic [1:0] mode_req,
    input  logic       mode_req_valid,
    output logic       mode_req_ready,
    output logic       pll_rst,
    output logic [1:0] clk_sel,
    output logic       clk_ena,
    output logic       video_rst,
    output logic       mode_done,
    output logic       mode_err,
`ifdef VIDEO_PLL_SEQ_STATS_EN
    output logic       fault,
    output logic [15:0] lock_loss_cnt,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`else
    output logic       fault
`endif
);

    localparam int C_CNT_MAX = max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, GATE_CYCLES);
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_RTY_W   = $clog2(MAX_RETRY + 1);

    state_t               r_state, w_state_nx;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [C_RTY_W-1:0]   r_retry, w_retry_nx;
    logic [1:0]           r_mode_new;
    logic                 r_switching;
    logic                 w_lock_s, w_cnt_zero, w_accept;

    logic       r_pll_rst, r_clk_ena, r_video_rst, r_ready, r_done, r_err, r_fault;
    logic [1:0] r_clk_sel;
    logic       w_pll_rst_nx, w_clk_ena_nx, w_video_rst_nx, w_ready_nx, w_done_nx, w_err_nx, w_fault_nx;
    logic [1:0] w_clk_sel_nx;

    video_pll_lock_sync u_lock_sync (
        .clk     (refclk),
        .rst     (rst),
        .i_async (pll_locked),
        .o_sync  (w_lock_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= RESET_PLL;
            r_cnt       <= C_CNT_W'(PLL_RST_CYCLES - 1);
            r_retry     <= '0;
            r_mode_new  <= MODE_DEFAULT;
            r_switching <= 1'b0;
            r_pll_rst   <= 1'b1;
            r_clk_sel   <= MODE_DEFAULT;
            r_clk_ena   <= 1'b0;
            r_video_rst <= 1'b1;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_retry     <= w_retry_nx;
            if (w_accept) r_mode_new <= mode_req;
            // Remembers that the current gate sequence belongs to a mode switch.
            r_switching <= (w_state_nx inside {SW_OFF, SW_SEL, GATE_ON}) &&
                           (r_switching || (r_state == RUN));
            r_pll_rst   <= w_pll_rst_nx;
            r_clk_sel   <= w_clk_sel_nx;
            r_clk_ena   <= w_clk_ena_nx;
            r_video_rst <= w_video_rst_nx;
            r_ready     <= w_ready_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
            r_fault     <= w_fault_nx;
        end
    end

    // Lock loss is checked first everywhere past WAIT_LOCK so it beats any request.
    always_comb begin
        w_state_nx = r_state;
        w_retry_nx = r_retry;
        w_accept   = 1'b0;
        case (r_state)
            RESET_PLL: if (w_cnt_zero) w_state_nx = WAIT_LOCK;
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nx = STABLE;
                end else if (w_cnt_zero) begin
                    w_retry_nx = r_retry + 1'b1;
                    w_state_nx = (w_retry_nx == C_RTY_W'(MAX_RETRY)) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                if (!w_lock_s) w_state_nx = WAIT_LOCK;
                else if (w_cnt_zero) begin
                    w_state_nx = GATE_ON;
                    w_retry_nx = '0;
                end
            end
            GATE_ON: begin
                if (!w_lock_s)       w_state_nx = WAIT_LOCK;
                else if (w_cnt_zero) w_state_nx = RUN;
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_nx = WAIT_LOCK;
                end else if (mode_req_valid) begin
                    w_accept = 1'b1;
                    if (mode_req != MODE_ILLEGAL && mode_req != r_clk_sel) w_state_nx = SW_OFF;
                end
            end
            SW_OFF: begin
                if (!w_lock_s)       w_state_nx = WAIT_LOCK;
                else if (w_cnt_zero) w_state_nx = SW_SEL;
            end
            SW_SEL: begin
                if (!w_lock_s)       w_state_nx = WAIT_LOCK;
                else if (w_cnt_zero) w_state_nx = GATE_ON;
            end
            FAULT:   w_state_nx = FAULT;
            default: w_state_nx = RESET_PLL;
        endcase
    end

    always_comb begin
        w_cnt_nx = r_cnt;
        if (w_state_nx != r_state) begin
            case (w_state_nx)
                RESET_PLL:              w_cnt_nx = C_CNT_W'(PLL_RST_CYCLES - 1);
                WAIT_LOCK:              w_cnt_nx = C_CNT_W'(LOCK_TIMEOUT - 1);
                STABLE:                 w_cnt_nx = C_CNT_W'(LOCK_STABLE - 1);
                GATE_ON, SW_OFF, SW_SEL: w_cnt_nx = C_CNT_W'(GATE_CYCLES - 1);
                default:                w_cnt_nx = '0;
            endcase
        end else if (!w_cnt_zero) begin
            w_cnt_nx = r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_pll_rst_nx   = (w_state_nx == RESET_PLL) || (w_state_nx == FAULT);
        w_clk_ena_nx   = (w_state_nx == GATE_ON) || (w_state_nx == RUN);
        w_video_rst_nx = (w_state_nx != RUN);
        w_ready_nx     = (w_state_nx == RUN);
        w_fault_nx     = (w_state_nx == FAULT);
        w_clk_sel_nx   = (r_state == SW_OFF && w_state_nx == SW_SEL) ? r_mode_new : r_clk_sel;
        w_done_nx      = (w_accept && mode_req == r_clk_sel) ||
                         (r_state == GATE_ON && w_state_nx == RUN && r_switching);
        w_err_nx       = w_accept && (mode_req == MODE_ILLEGAL);
    end

    assign pll_rst        = r_pll_rst;
    assign clk_sel        = r_clk_sel;
    assign clk_ena        = r_clk_ena;
    assign video_rst      = r_video_rst;
    assign mode_req_ready = r_ready;
    assign mode_done      = r_done;
    assign mode_err       = r_err;
    assign fault          = r_fault;

`ifdef VIDEO_PLL_SEQ_STATS_EN
    logic [15:0] r_lock_loss_cnt;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_loss_cnt <= '0;
        end else if (r_state == RUN && w_state_nx == WAIT_LOCK && r_lock_loss_cnt != 16'hFFFF) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
    assign retry_cnt     = r_retry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_pll_sequencer
//  Brief    : Directed self-checking bench for video_pll_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_pll_sequencer;
    import video_pll_seq_pkg::*;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic [1:0] mode_req = 2'd0;
    logic       mode_req_valid = 1'b0;
    logic       mode_req_ready, pll_rst, clk_ena, video_rst, mode_done, mode_err, fault;
    logic [1:0] clk_sel;
`ifdef VIDEO_PLL_SEQ_STATS_EN
    logic [15:0] lock_loss_cnt;
    logic [1:0]  retry_cnt;
`endif

    int checks = 0;
    int errors = 0;

    video_pll_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .LOCK_STABLE    (8),
        .GATE_CYCLES    (2),
        .MAX_RETRY      (2),
        .MODE_DEFAULT   (2'd0)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .pll_rst        (pll_rst),
        .clk_sel        (clk_sel),
        .clk_ena        (clk_ena),
        .video_rst      (video_rst),
        .mode_done      (mode_done),
        .mode_err       (mode_err),
`ifdef VIDEO_PLL_SEQ_STATS_EN
        .fault          (fault),
        .lock_loss_cnt  (lock_loss_cnt),
        .retry_cnt      (retry_cnt)
`else
        .fault          (fault)
`endif
    );

    always #10 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        step(3);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_clk_sel", clk_sel, 0);
        check("rst_clk_ena", clk_ena, 0);
        check("rst_video_rst", video_rst, 1);
        check("rst_ready", mode_req_ready, 0);
        check("rst_done", mode_done, 0);
        check("rst_err", mode_err, 0);
        check("rst_fault", fault, 0);
        rst = 1'b0;

        // Bring-up with lock from cycle 6
        for (int c = 1; c <= 18; c++) begin
            step(1);
            if (c == 5) pll_locked = 1'b1;
            case (c)
                3:  check("t1_pll_rst_hi", pll_rst, 1);
                4:  check("t1_pll_rst_lo", pll_rst, 0);
                15: check("t1_ena_early", clk_ena, 0);
                16: begin
                    check("t1_ena_on", clk_ena, 1);
                    check("t1_vrst_hold", video_rst, 1);
                end
                18: begin
                    check("t1_vrst_off", video_rst, 0);
                    check("t1_ready", mode_req_ready, 1);
                    check("t1_sel", clk_sel, 0);
                end
                default: ;
            endcase
        end

        // Switch to 40 MHz
        mode_req = MODE_40;
        mode_req_valid = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            step(1);
            if (c == 0) mode_req_valid = 1'b0;
            case (c)
                0: begin
                    check("t3_ena_off", clk_ena, 0);
                    check("t3_ready_off", mode_req_ready, 0);
                    check("t3_vrst_on", video_rst, 1);
                end
                1: check("t3_sel_old", clk_sel, 0);
                2: begin
                    check("t3_sel_new", clk_sel, 1);
                    check("t3_ena_still_off", clk_ena, 0);
                end
                3: check("t3_ena_off2", clk_ena, 0);
                4: begin
                    check("t3_ena_on", clk_ena, 1);
                    check("t3_vrst_hold", video_rst, 1);
                end
                5: check("t3_done_early", mode_done, 0);
                6: begin
                    check("t3_vrst_off", video_rst, 0);
                    check("t3_done", mode_done, 1);
                    check("t3_ready_on", mode_req_ready, 1);
                end
                7: check("t3_done_pulse", mode_done, 0);
                default: ;
            endcase
        end

        // Illegal mode, then current mode
        mode_req = MODE_ILLEGAL;
        mode_req_valid = 1'b1;
        step(1);
        mode_req_valid = 1'b0;
        check("t4_err", mode_err, 1);
        check("t4_err_sel", clk_sel, 1);
        check("t4_err_nodone", mode_done, 0);
        check("t4_err_ena", clk_ena, 1);
        step(1);
        check("t4_err_pulse", mode_err, 0);
        mode_req = MODE_40;
        mode_req_valid = 1'b1;
        step(1);
        mode_req_valid = 1'b0;
        check("t4_same_done", mode_done, 1);
        check("t4_same_ena", clk_ena, 1);
        check("t4_same_noerr", mode_err, 0);
        step(1);
        check("t4_same_pulse", mode_done, 0);

        // Lock loss coinciding with a request at the synchronized lock
        pll_locked = 1'b0;
        step(2);
        mode_req = MODE_33;
        mode_req_valid = 1'b1;
        step(1);
        check("t5_vrst_on", video_rst, 1);
        check("t5_ena_off", clk_ena, 0);
        check("t5_ready_off", mode_req_ready, 0);
        check("t5_sel_kept", clk_sel, 1);
`ifdef VIDEO_PLL_SEQ_STATS_EN
        check("t5_loss_cnt", lock_loss_cnt, 1);
`endif
        pll_locked = 1'b1;
        for (int c = 4; c <= 17; c++) begin
            step(1);
            case (c)
                15: check("t5_not_ready", mode_req_ready, 0);
                16: begin
                    check("t5_ready", mode_req_ready, 1);
                    check("t5_vrst_off", video_rst, 0);
                end
                17: begin
                    check("t5_accept_ena", clk_ena, 0);
                    check("t5_accept_ready", mode_req_ready, 0);
                    mode_req_valid = 1'b0;
                end
                default: ;
            endcase
        end
        step(6);
        check("t5_sel_new", clk_sel, 2);
        check("t5_done", mode_done, 1);

        // Leave RUN, then glitch lock while in STABLE
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        check("t6_vrst_loss", video_rst, 1);
        for (int d = 4; d <= 19; d++) begin
            step(1);
            if (d == 5) pll_locked = 1'b0;
            if (d == 6) pll_locked = 1'b1;
            case (d)
                12: check("t6_restart_a", clk_ena, 0);
                16: check("t6_restart_b", clk_ena, 0);
                17: check("t6_ena_on", clk_ena, 1);
                19: begin
                    check("t6_ready", mode_req_ready, 1);
                    check("t6_sel", clk_sel, 2);
                end
                default: ;
            endcase
        end
`ifdef VIDEO_PLL_SEQ_STATS_EN
        check("t6_loss_cnt", lock_loss_cnt, 2);
`endif

        // No lock: two timeouts then FAULT
        rst = 1'b1;
        pll_locked = 1'b0;
        step(2);
        check("t2_rst_sel", clk_sel, 0);
        rst = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            step(1);
            if (c == 50) pll_locked = 1'b1;
            case (c)
                4:  check("t2_pll_rst_lo", pll_rst, 0);
                23: check("t2_wait_end", pll_rst, 0);
                24: begin
                    check("t2_retry_rst", pll_rst, 1);
`ifdef VIDEO_PLL_SEQ_STATS_EN
                    check("t2_retry_cnt1", retry_cnt, 1);
`endif
                end
                27: check("t2_retry_rst_hold", pll_rst, 1);
                28: check("t2_retry_rst_lo", pll_rst, 0);
                47: check("t2_no_fault_yet", fault, 0);
                48: begin
                    check("t2_fault", fault, 1);
                    check("t2_fault_pll_rst", pll_rst, 1);
`ifdef VIDEO_PLL_SEQ_STATS_EN
                    check("t2_retry_cnt2", retry_cnt, 2);
`endif
                end
                60: begin
                    check("t2_fault_sticky", fault, 1);
                    check("t2_fault_pll_hold", pll_rst, 1);
                    check("t2_fault_ena", clk_ena, 0);
                    check("t2_fault_vrst", video_rst, 1);
                end
                default: ;
            endcase
        end
        rst = 1'b1;
        step(1);
        check("t2_fault_clear", fault, 0);
        check("t2_clear_pll_rst", pll_rst, 1);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
